icmp_pipe_unit: RTL and testbench
=================================

// Module: icmp_pipe_unit
// PURPOSE
//  Multi-lane, pipelined integer compare unit for HLS datapaths; successor to the single-op combinational compare.
//  Opcode (LLVM icmp predicate) is a per-beat runtime input, not a build-time string.
//  Each beat carries NUM_LANES lhs/rhs pairs plus a tag; results leave after PIPE_STAGES cycles.
//  Uses a valid/ready handshake with bubble-collapsing back-pressure between scheduler and consumer.
// PARAMETERS
//  DATA_W      32  operand width per lane (>=1)
//  NUM_LANES   4   parallel compare lanes (>=1)
//  PIPE_STAGES 2   register stages, input to output (>=1)
//  TAG_W       8   passthrough tag width (>=1)
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  asynchronous, active-high reset
//  in_valid   in   1                  input beat valid
//  in_ready   out  1                  unit accepts beat this cycle
//  in_op      in   4                  predicate code: 0 eq,1 ne,2 ugt,3 uge,4 ult,5 ule,6 sgt,7 sge,8 slt,9 sle
//  in_lhs     in   NUM_LANES*DATA_W   lane i = bits [i*DATA_W +: DATA_W]
//  in_rhs     in   NUM_LANES*DATA_W   as in_lhs
//  in_tag     in   TAG_W              carried unchanged to out_tag
//  out_valid  out  1                  output beat valid
//  out_ready  in   1                  consumer accepts output
//  out_ret    out  NUM_LANES          per-lane compare result
//  out_any    out  1                  |out_ret
//  out_all    out  1                  &out_ret
//  out_tag    out  TAG_W              tag of the beat
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits 0; out_valid=0; out_ret/out_tag/out_any/out_all=0.
//  - Compare is combinational ahead of stage 0; stages 1..PIPE_STAGES-1 are plain registers.
//  - Signed ops use two's complement at DATA_W; unsigned ops use the raw value. ule is lhs<=rhs.
//  - Stage k (0..N-1) holds v[k]; adv[N-1]=out_ready; stage k loads from k-1 when !v[k] || adv[k].
//  - Ready chain: in_ready = !v[0] || (v[0] && advance of stage 0). Combinational from out_ready;
//    bubbles collapse, so there is no throughput loss while out_ready=1.
//  - Transfer: input fires when in_valid&&in_ready; output fires when out_valid&&out_ready.
//  - Latency: a beat accepted in cycle t appears as out_valid in cycle t+PIPE_STAGES if no stall.
//  - Sustained throughput is 1 beat/cycle.
//  - Stall: while out_valid&&!out_ready, out_* hold stable; the pipe fills, then in_ready=0.
//    Exactly PIPE_STAGES beats are buffered, none dropped or duplicated.
//  - Accept and drain in the same cycle with a full pipe is legal: every stage shifts.
//  - Opcodes 10..15 are illegal; see CONFIGURATION.
//  - in_* are sampled only on an accepted transfer; values while !in_valid are ignored.
//  - Reset mid-operation discards all in-flight beats; the first accept after release sees an empty pipe.
//  - Order is preserved; out_tag always matches its beat's out_ret.
// CONFIGURATION
//  ICMP_PIPE_UNIT_ILLEGAL_EN defined:
//   - adds output port out_err (1 bit), pipelined with the beat; reset value 0.
//   - out_err=1 for opcodes 10..15; out_ret is forced to 0 for such beats.
//  Not defined:
//   - no out_err port; opcodes 10..15 yield out_ret=0, out_any=0, out_all=0.
//  Both builds: illegal beats still consume a pipe slot and handshake normally.
// TESTING
//  1. Reset 3 cycles, then idle -> out_valid=0, in_ready=1, out_ret=0.
//  2. DATA_W=32, lanes: lhs {5, 0xFFFFFFFF, 7, 0}, rhs {5, 1, 9, 0}.
//     op=0 eq -> out_ret=4'b1001; op=8 slt -> 4'b0110; op=2 ugt -> 4'b0010.
//     Each appears PIPE_STAGES cycles after accept.
//  3. op=5 ule, lhs=rhs=0x80000000 on all lanes -> out_ret=4'b1111, out_all=1, out_any=1.
//  4. out_ready=1, back-to-back beats with tags 0..15 -> 16 outputs on consecutive cycles, tags in order.
//  5. Streaming; hold out_ready=0 for 6 cycles.
//     -> in_ready falls after PIPE_STAGES more accepts; out_* stable; all tags delivered, none lost.
//  6. op=12 -> out_ret=0; out_err=1 with macro defined.
//     Then assert rst with 2 beats in flight -> out_valid=0 next sample, no stale beat after release.

Source files
------------

// File: rtl/icmp_pipe_unit.sv
// Multi-lane pipelined integer compare (LLVM icmp predicates) with valid/ready flow control.
// Optional build macro ICMP_PIPE_UNIT_ILLEGAL_EN adds out_err flagging opcodes 10..15.
module icmp_pipe_unit #(
  parameter int DATA_W      = 32,
  parameter int NUM_LANES   = 4,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_op,
  input  logic [NUM_LANES*DATA_W-1:0]   in_lhs,
  input  logic [NUM_LANES*DATA_W-1:0]   in_rhs,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_LANES-1:0]          out_ret,
  output logic                          out_any,
  output logic                          out_all,
`ifdef ICMP_PIPE_UNIT_ILLEGAL_EN
  output logic                          out_err,
`endif
  output logic [TAG_W-1:0]              out_tag
);

  typedef enum logic [3:0] {
    OP_EQ  = 4'd0,
    OP_NE  = 4'd1,
    OP_UGT = 4'd2,
    OP_UGE = 4'd3,
    OP_ULT = 4'd4,
    OP_ULE = 4'd5,
    OP_SGT = 4'd6,
    OP_SGE = 4'd7,
    OP_SLT = 4'd8,
    OP_SLE = 4'd9
  } op_e;

  logic [NUM_LANES-1:0] cmp_ret;
  logic                 illegal;
  logic [DATA_W-1:0]    lane_a;
  logic [DATA_W-1:0]    lane_b;

  logic [PIPE_STAGES-1:0] v_q;
  logic [PIPE_STAGES-1:0] ld;
  logic [NUM_LANES-1:0]   ret_q [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_q [PIPE_STAGES];
`ifdef ICMP_PIPE_UNIT_ILLEGAL_EN
  logic                   err_q [PIPE_STAGES];
`endif

  always_comb begin
    cmp_ret = '0;
    lane_a  = '0;
    lane_b  = '0;
    illegal = (in_op > 4'd9);
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_a = in_lhs[i*DATA_W +: DATA_W];
      lane_b = in_rhs[i*DATA_W +: DATA_W];
      case (op_e'(in_op))
        OP_EQ:   cmp_ret[i] = (lane_a == lane_b);
        OP_NE:   cmp_ret[i] = (lane_a != lane_b);
        OP_UGT:  cmp_ret[i] = (lane_a >  lane_b);
        OP_UGE:  cmp_ret[i] = (lane_a >= lane_b);
        OP_ULT:  cmp_ret[i] = (lane_a <  lane_b);
        OP_ULE:  cmp_ret[i] = (lane_a <= lane_b);
        OP_SGT:  cmp_ret[i] = ($signed(lane_a) >  $signed(lane_b));
        OP_SGE:  cmp_ret[i] = ($signed(lane_a) >= $signed(lane_b));
        OP_SLT:  cmp_ret[i] = ($signed(lane_a) <  $signed(lane_b));
        OP_SLE:  cmp_ret[i] = ($signed(lane_a) <= $signed(lane_b));
        default: cmp_ret[i] = 1'b0;
      endcase
    end
  end

  // Load enables ripple back from the consumer so empty stages never block upstream beats.
  always_comb begin
    logic carry;
    ld    = '0;
    carry = out_ready;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      ld[k] = !v_q[k] || carry;
      carry = ld[k];
    end
  end

  assign in_ready = ld[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        v_q[k]   <= 1'b0;
        ret_q[k] <= '0;
        tag_q[k] <= '0;
`ifdef ICMP_PIPE_UNIT_ILLEGAL_EN
        err_q[k] <= 1'b0;
`endif
      end
    end else begin
      if (ld[0]) begin
        v_q[0] <= in_valid;
        if (in_valid) begin
          ret_q[0] <= cmp_ret;
          tag_q[0] <= in_tag;
`ifdef ICMP_PIPE_UNIT_ILLEGAL_EN
          err_q[0] <= illegal;
`endif
        end
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (ld[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            ret_q[k] <= ret_q[k-1];
            tag_q[k] <= tag_q[k-1];
`ifdef ICMP_PIPE_UNIT_ILLEGAL_EN
            err_q[k] <= err_q[k-1];
`endif
          end
        end
      end
    end
  end

  assign out_valid = v_q[PIPE_STAGES-1];
  assign out_ret   = ret_q[PIPE_STAGES-1];
  assign out_tag   = tag_q[PIPE_STAGES-1];
  assign out_any   = |out_ret;
  assign out_all   = &out_ret;
`ifdef ICMP_PIPE_UNIT_ILLEGAL_EN
  assign out_err   = err_q[PIPE_STAGES-1];
`endif

endmodule

// File: tb/tb_icmp_pipe_unit.sv
// Self-checking bench for icmp_pipe_unit: directed cases plus randomized traffic
// against a queue-based reference model of the compare and the handshake.
module tb_icmp_pipe_unit;
  localparam int DATA_W      = 32;
  localparam int NUM_LANES   = 4;
  localparam int PIPE_STAGES = 2;
  localparam int TAG_W       = 8;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        in_valid;
  logic                        in_ready;
  logic [3:0]                  in_op;
  logic [NUM_LANES*DATA_W-1:0] in_lhs;
  logic [NUM_LANES*DATA_W-1:0] in_rhs;
  logic [TAG_W-1:0]            in_tag;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_LANES-1:0]        out_ret;
  logic                        out_any;
  logic                        out_all;
  logic [TAG_W-1:0]            out_tag;
`ifdef ICMP_PIPE_UNIT_ILLEGAL_EN
  logic                        out_err;
`endif

  icmp_pipe_unit #(
    .DATA_W(DATA_W), .NUM_LANES(NUM_LANES), .PIPE_STAGES(PIPE_STAGES), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_lhs(in_lhs), .in_rhs(in_rhs), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ret(out_ret), .out_any(out_any), .out_all(out_all),
`ifdef ICMP_PIPE_UNIT_ILLEGAL_EN
    .out_err(out_err),
`endif
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_LANES-1:0] ret;
    logic [TAG_W-1:0]     tag;
    logic                 err;
    int                   acc;
  } beat_t;

  beat_t                expq[$];
  int                   cyc = 0;
  int                   nChecks = 0;
  int                   nFails = 0;
  int                   inFires = 0;
  int                   outFires = 0;
  bit                   checkLat = 1'b1;
  bit                   lastFire;
  logic [NUM_LANES-1:0] lastRet;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference compare: operands are lifted into 64-bit integers, signed view by subtracting 2^32.
  function automatic logic refLane(input int op, input logic [31:0] a, input logic [31:0] b);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = a[31] ? ua - 64'sd4294967296 : ua;
    longint sb = b[31] ? ub - 64'sd4294967296 : ub;
    case (op)
      0: return ua == ub;
      1: return ua != ub;
      2: return ua > ub;
      3: return ua >= ub;
      4: return ua < ub;
      5: return ua <= ub;
      6: return sa > sb;
      7: return sa >= sb;
      8: return sa < sb;
      9: return sa <= sb;
      default: return 1'b0;
    endcase
  endfunction

  function automatic beat_t refBeat(input logic [3:0] op, input logic [NUM_LANES*DATA_W-1:0] l,
                                    input logic [NUM_LANES*DATA_W-1:0] r, input logic [TAG_W-1:0] t);
    beat_t b;
    for (int i = 0; i < NUM_LANES; i++)
      b.ret[i] = refLane(int'(op), l[i*DATA_W +: DATA_W], r[i*DATA_W +: DATA_W]);
    b.tag = t;
    b.err = (op > 4'd9);
    b.acc = cyc;
    return b;
  endfunction

  function automatic logic [NUM_LANES*DATA_W-1:0] randOperand();
    logic [NUM_LANES*DATA_W-1:0] v;
    logic [31:0] pick [5];
    pick[0] = 32'h0; pick[1] = 32'h1; pick[2] = 32'h7FFFFFFF;
    pick[3] = 32'h80000000; pick[4] = 32'hFFFFFFFF;
    for (int i = 0; i < NUM_LANES; i++)
      v[i*DATA_W +: DATA_W] = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 4)] : $urandom_range(0, 3);
    return v;
  endfunction

  // One clock cycle: drive inputs, observe both handshakes before the edge, update the model.
  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [NUM_LANES*DATA_W-1:0] l,
                               input logic [NUM_LANES*DATA_W-1:0] r, input logic [TAG_W-1:0] t,
                               input logic ordy);
    beat_t e;
    in_valid = v; in_op = op; in_lhs = l; in_rhs = r; in_tag = t; out_ready = ordy;
    #1;
    lastFire = 1'b0;
    if (out_valid && out_ready) begin
      lastFire = 1'b1;
      lastRet  = out_ret;
      outFires++;
      if (expq.size() == 0) begin
        checkOutput("unexpected_out", 64'd1, 64'd0);
      end else begin
        e = expq.pop_front();
        checkOutput("ret", 64'(out_ret), 64'(e.ret));
        checkOutput("any", 64'(out_any), 64'(e.ret != '0));
        checkOutput("all", 64'(out_all), 64'(e.ret == '1));
        checkOutput("tag", 64'(out_tag), 64'(e.tag));
`ifdef ICMP_PIPE_UNIT_ILLEGAL_EN
        checkOutput("err", 64'(out_err), 64'(e.err));
`endif
        if (checkLat) checkOutput("latency", 64'(cyc - e.acc), 64'(PIPE_STAGES));
      end
    end
    if (in_valid && in_ready) begin
      inFires++;
      expq.push_back(refBeat(op, l, r, t));
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, '0, '0, '0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && expq.size() > 0; i++) idle(1);
    checkOutput("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  logic [NUM_LANES*DATA_W-1:0] dirL, dirR;
  logic [3:0]                  dirOp  [3];
  logic [NUM_LANES-1:0]        dirExp [3];
  int                          f0, a0;
  bit                          snap;
  logic [NUM_LANES-1:0]        snapRet;
  logic [TAG_W-1:0]            snapTag;

  initial begin
    rst = 1'b1; in_valid = 0; in_op = 0; in_lhs = '0; in_rhs = '0; in_tag = '0; out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_ret", 64'(out_ret), 64'd0);
    checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
    checkOutput("rst_any_all", 64'({out_any, out_all}), 64'd0);
    @(negedge clk);

    dirL = {32'd0, 32'd7, 32'hFFFFFFFF, 32'd5};
    dirR = {32'd0, 32'd9, 32'd1, 32'd5};
    dirOp[0] = 4'd0; dirExp[0] = 4'b1001;
    dirOp[1] = 4'd8; dirExp[1] = 4'b0110;
    dirOp[2] = 4'd2; dirExp[2] = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, dirOp[k], dirL, dirR, TAG_W'(8'hA0 + k), 1'b1);
      idle(PIPE_STAGES);
      checkOutput("dir_fire", 64'(lastFire), 64'd1);
      checkOutput("dir_ret", 64'(lastRet), 64'(dirExp[k]));
    end

    applyStimulus(1'b1, 4'd5, {NUM_LANES{32'h80000000}}, {NUM_LANES{32'h80000000}}, 8'hB0, 1'b1);
    idle(PIPE_STAGES);
    checkOutput("ule_ret", 64'(lastRet), 64'hF);

    f0 = outFires; a0 = inFires;
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 4'($urandom_range(0, 9)), randOperand(), randOperand(), TAG_W'(i), 1'b1);
    idle(PIPE_STAGES);
    checkOutput("b2b_accepts", 64'(inFires - a0), 64'd16);
    checkOutput("b2b_outputs", 64'(outFires - f0), 64'd16);
    drain();

    checkLat = 1'b0;
    a0 = inFires; snap = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 4'($urandom_range(0, 9)), randOperand(), randOperand(), TAG_W'(8'h40 + i), 1'b0);
      if (out_valid) begin
        if (!snap) begin
          snap = 1'b1; snapRet = out_ret; snapTag = out_tag;
        end else begin
          checkOutput("stall_ret_stable", 64'(out_ret), 64'(snapRet));
          checkOutput("stall_tag_stable", 64'(out_tag), 64'(snapTag));
        end
      end
    end
    #1;
    checkOutput("stall_accepts", 64'(inFires - a0), 64'(PIPE_STAGES));
    checkOutput("stall_buffered", 64'(expq.size()), 64'(PIPE_STAGES));
    checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    drain();
    checkLat = 1'b1;

    applyStimulus(1'b1, 4'd12, dirL, dirR, 8'hC0, 1'b1);
    idle(PIPE_STAGES);
    checkOutput("illegal_fire", 64'(lastFire), 64'd1);
    checkOutput("illegal_ret", 64'(lastRet), 64'd0);

    applyStimulus(1'b1, 4'd0, dirL, dirR, 8'hD0, 1'b1);
    applyStimulus(1'b1, 4'd1, dirL, dirR, 8'hD1, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    #1;
    checkOutput("postrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    applyStimulus(1'b1, 4'd0, dirL, dirR, 8'hE0, 1'b1);
    idle(PIPE_STAGES);
    checkOutput("postrst_ret", 64'(lastRet), 64'(4'b1001));

    checkLat = 1'b0;
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), randOperand(), randOperand(),
                    TAG_W'(i), ($urandom_range(0, 3) != 0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end
endmodule
